pwm_duty_sequencer: RTL and testbench

PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

---
 rtl/pwm_ctrl_pkg.sv | 4 +
 rtl/pwm_period_timer.sv | 16 +
 rtl/pwm_duty_sequencer.sv | 76 +++++++
 tb/tb_pwm_duty_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared types for the PWM control blocks
package pwm_ctrl_pkg;
  typedef enum logic {IDLE, RAMP} state_t;
endpackage

// File: rtl/pwm_period_timer.sv
// pwm_period_timer: free-running period counter with an all-ones wrap flag
module pwm_period_timer #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  output logic wrap
);
  logic [WIDTH-1:0] cnt;
  // counter runs every cycle so it stays aligned with the PWM generator
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
  assign wrap = &cnt;
endmodule

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: ramps the PWM duty toward a target only at period boundaries
module pwm_duty_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PERIODS_PER_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] tgt_duty,
  input  logic [WIDTH-1:0] step,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] duty,
  output logic             period_wrap,
  output logic             busy,
  output logic             done
);
  state_t state, state_n;
  logic [WIDTH-1:0] tgt, tgt_n, stp, stp_n, duty_n, eff;
  logic [7:0] pcnt, pcnt_n;
  logic [WIDTH:0] diff, moved;
  logic xfer, upd, close, done_n;
  pwm_period_timer #(.WIDTH(WIDTH)) u_timer (.clk(clk), .reset(reset), .wrap(period_wrap));
  assign tgt_ready = (state == IDLE) && enable;
  assign busy = (state == RAMP);
  // next-state, ramp arithmetic in WIDTH+1 bits so duty cannot wrap or overshoot
  always_comb begin
    xfer = tgt_valid && tgt_ready;
    eff = enable ? tgt : '0;
    diff = (eff > duty) ? {1'b0, eff} - {1'b0, duty} : {1'b0, duty} - {1'b0, eff};
    close = diff <= {1'b0, stp};
    moved = (eff > duty) ? {1'b0, duty} + {1'b0, stp} : {1'b0, duty} - {1'b0, stp};
    upd = (state == RAMP) && period_wrap && (pcnt == 8'(PERIODS_PER_STEP - 1));
    state_n = state;
    tgt_n = eff;
    stp_n = stp;
    duty_n = duty;
    pcnt_n = pcnt;
    done_n = 1'b0;
    if (xfer) begin
      tgt_n = tgt_duty;
      stp_n = (step == '0) ? WIDTH'(1) : step;
      pcnt_n = '0;
      state_n = RAMP;
    end else if (state == RAMP) begin
      if (period_wrap) pcnt_n = upd ? 8'd0 : pcnt + 8'd1;
      if (upd) begin
        duty_n = close ? eff : moved[WIDTH-1:0];
        done_n = close;
        state_n = close ? IDLE : RAMP;
      end
    end else if (!enable && duty != '0) begin
      state_n = RAMP;
    end
  end
  // state, latched target/step and the registered duty seen by the PWM generator
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tgt <= '0;
      stp <= WIDTH'(1);
      duty <= '0;
      pcnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      tgt <= tgt_n;
      stp <= stp_n;
      duty <= duty_n;
      pcnt <= pcnt_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb_pwm_duty_sequencer: directed checks of duty ramping at period wraps
module tb_pwm_duty_sequencer;
  logic clk = 1'b0;
  logic reset, enable, tgt_valid, tgt_ready, period_wrap, busy, done;
  logic [7:0] tgt_duty, step, duty;
  int pass = 0, total = 0;
  pwm_duty_sequencer #(.WIDTH(8), .PERIODS_PER_STEP(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tgt_duty(tgt_duty), .step(step),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .duty(duty),
    .period_wrap(period_wrap), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic wait_wrap(input string tag);
    int n = 0;
    bit moved = 0;
    logic [7:0] d0 = duty;
    while (period_wrap !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
      if (duty !== d0) moved = 1;
    end
    chk({tag, "_wrap_seen"}, 32'(n < 600), 1);
    chk({tag, "_no_midperiod_change"}, 32'(moved), 0);
    @(negedge clk);
  endtask
  task automatic step_to(input string tag, input int exp, input bit last);
    wait_wrap(tag);
    chk({tag, "_duty"}, duty, exp);
    chk({tag, "_done"}, done, last);
    chk({tag, "_busy"}, busy, !last);
  endtask
  task automatic offer(input int t, input int s);
    tgt_duty = 8'(t);
    step = 8'(s);
    tgt_valid = 1;
    @(negedge clk);
    tgt_valid = 0;
    chk("offer_busy", busy, 1);
    chk("offer_ready_low", tgt_ready, 0);
  endtask
  initial begin
    int n;
    reset = 1; enable = 0; tgt_valid = 0; tgt_duty = 0; step = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", period_wrap, 0);
    reset = 0;
    n = 0;
    while (period_wrap !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    chk("first_wrap_at", n, 255);
    enable = 1;
    @(negedge clk);
    chk("ready_idle", tgt_ready, 1);
    offer(100, 25);
    step_to("up25", 25, 0);
    step_to("up50", 50, 0);
    step_to("up75", 75, 0);
    step_to("up100", 100, 1);
    chk("ready_after_up", tgt_ready, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    offer(0, 30);
    step_to("dn70", 70, 0);
    step_to("dn40", 40, 0);
    step_to("dn10", 10, 0);
    step_to("dn0", 0, 1);
    offer(60, 20);
    step_to("ig20", 20, 0);
    tgt_duty = 200; step = 100; tgt_valid = 1;
    @(negedge clk);
    chk("ig_ready_low", tgt_ready, 0);
    tgt_valid = 0;
    step_to("ig40", 40, 0);
    step_to("ig60", 60, 1);
    wait_wrap("ig_hold");
    chk("ig_hold_duty", duty, 60);
    chk("ig_hold_busy", busy, 0);
    offer(100, 25);
    step_to("re85", 85, 0);
    step_to("re100", 100, 1);
    enable = 0; tgt_duty = 90; step = 5; tgt_valid = 1;
    @(negedge clk);
    chk("stop_busy", busy, 1);
    chk("stop_ready", tgt_ready, 0);
    step_to("st75", 75, 0);
    chk("st_ready75", tgt_ready, 0);
    step_to("st50", 50, 0);
    step_to("st25", 25, 0);
    step_to("st0", 0, 1);
    chk("st_ready_idle", tgt_ready, 0);
    wait_wrap("st_hold");
    chk("st_hold_duty", duty, 0);
    chk("st_hold_busy", busy, 0);
    tgt_valid = 0;
    enable = 1;
    @(negedge clk);
    offer(100, 25);
    step_to("mr25", 25, 0);
    step_to("mr50", 50, 0);
    repeat (40) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mr_duty", duty, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_wrap", period_wrap, 0);
    chk("mr_ready", tgt_ready, 1);
    reset = 0;
    n = 0;
    while (period_wrap !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
      if (done !== 1'b0) chk("mr_no_done", done, 0);
    end
    chk("mr_wrap_restart", n, 255);
    @(negedge clk);
    offer(3, 0);
    step_to("s0_1", 1, 0);
    step_to("s0_2", 2, 0);
    step_to("s0_3", 3, 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
